// File: rtl/dma_axi_w_feeder.sv
// Feeder stage for the DMA AXI write master: buffers source words in a FWFT FIFO
// and presents them to the master as INCR bursts of at most burst_len+1 beats.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module dma_axi_w_feeder #(
  parameter int DMA_DATA_W      = 32,
  parameter int ADDR_W          = `AXI_ADDR_W,
  parameter int LEN_W           = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LEN_W-1:0]        total_words,
  input  logic [`AXI_LEN_W-1:0]   burst_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  input  logic [DMA_DATA_W-1:0]   in_data,
  input  logic [DMA_DATA_W/8-1:0] in_strb,
  output logic                    in_ready,
  output logic                    valid,
  output logic [ADDR_W-1:0]       addr,
  output logic [DMA_DATA_W-1:0]   wdata,
  output logic [DMA_DATA_W/8-1:0] wstrb,
  output logic [`AXI_LEN_W-1:0]   dma_len,
  input  logic                    ready,
  input  logic                    dma_ready
);

  localparam int STRB_W = DMA_DATA_W / 8;
  localparam int BL_W   = `AXI_LEN_W;
  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int PTR_W  = FIFO_DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_BURST,
    S_WAIT_RESP,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BL_W-1:0]    dma_len_q, dma_len_d;
  logic [BL_W-1:0]    burst_len_q, burst_len_d;
  logic [BL_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0]   total_q, total_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   pushed_q, pushed_d;

  logic [DMA_DATA_W-1:0] data_mem [DEPTH];
  logic [STRB_W-1:0]     strb_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic               push, pop;
  logic [LEN_W:0]     bl_plus1, rem_ext, beats, count_ext;
  logic               fifo_enough;
  logic [ADDR_W-1:0]  burst_bytes;

  assign in_ready = busy_q & (count_q != CNT_W'(DEPTH)) & (pushed_q < total_q);
  assign push     = in_valid & in_ready;
  assign pop      = ready & (state_q == S_BURST);

  // Burst size is bounded by both the programmed burst length and the words still owed.
  assign bl_plus1    = (LEN_W+1)'(burst_len_q) + (LEN_W+1)'(1);
  assign rem_ext     = (LEN_W+1)'(remaining_q);
  assign beats       = (bl_plus1 < rem_ext) ? bl_plus1 : rem_ext;
  assign count_ext   = (LEN_W+1)'(count_q);
  assign fifo_enough = count_ext >= beats;
  assign burst_bytes = ADDR_W'((BL_W+1)'(dma_len_q) + (BL_W+1)'(1)) * ADDR_W'(STRB_W);

  assign busy    = busy_q;
  assign done    = done_q;
  assign valid   = valid_q;
  assign addr    = addr_q;
  assign dma_len = dma_len_q;
  assign wdata   = data_mem[rd_ptr_q];
  assign wstrb   = strb_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    addr_d      = addr_q;
    dma_len_d   = dma_len_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    total_d     = total_q;
    remaining_d = remaining_q;
    pushed_d    = pushed_q + LEN_W'(push);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d     = total_words;
          burst_len_d = burst_len;
          remaining_d = total_words;
          addr_d      = base_addr;
          pushed_d    = '0;
          busy_d      = 1'b1;
          state_d     = (total_words == '0) ? S_FINISH : S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (fifo_enough && dma_ready) begin
          dma_len_d  = beats[BL_W-1:0] - BL_W'(1);
          valid_d    = 1'b1;
          beat_cnt_d = '0;
          state_d    = S_BURST;
        end
      end
      S_BURST: begin
        if (ready) begin
          beat_cnt_d  = beat_cnt_q + BL_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (beat_cnt_q == dma_len_q) begin
            valid_d = 1'b0;
            addr_d  = addr_q + burst_bytes;
            state_d = S_WAIT_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        if (dma_ready) begin
          state_d = (remaining_q == '0) ? S_FINISH : S_WAIT_DATA;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      dma_len_q   <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      total_q     <= '0;
      remaining_q <= '0;
      pushed_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      dma_len_q   <= dma_len_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      total_q     <= total_d;
      remaining_q <= remaining_d;
      pushed_q    <= pushed_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; flushing the pointers and count empties it.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      strb_mem[wr_ptr_q] <= in_strb;
    end
  end

endmodule

// File: tb/tb_dma_axi_w_feeder.sv
// Randomized bench for dma_axi_w_feeder: a behavioural write-master and source model
// derive the expected burst list, word order and handshake behaviour from the transfer rules.

`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif

module tb_dma_axi_w_feeder;

  localparam int DW    = 32;
  localparam int AW    = `AXI_ADDR_W;
  localparam int LW    = 16;
  localparam int BLW   = `AXI_LEN_W;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [LW-1:0]  total_words = '0;
  logic [BLW-1:0] burst_len = '0;
  logic           busy, done, in_ready, valid;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic [SW-1:0]  in_strb = '0;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic [BLW-1:0] dma_len;
  logic           ready = 1'b0;
  logic           dma_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] words [64];
  logic [SW-1:0] strbs [64];

  dma_axi_w_feeder #(
    .DMA_DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .total_words(total_words), .burst_len(burst_len), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_strb(in_strb), .in_ready(in_ready),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb), .dma_len(dma_len),
    .ready(ready), .dma_ready(dma_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_words(input int n, input bit seq);
    for (int i = 0; i < n; i++) begin
      words[i] = seq ? DW'(32'hA0 + i) : DW'($urandom);
      strbs[i] = seq ? '1 : SW'($urandom);
    end
  endtask

  // Runs one transfer with a modelled source and write master. Returns early
  // right after pop number abort_pops has been consumed when abort_pops > 0.
  task automatic run_xfer(input logic [AW-1:0] base, input int total, input int bl,
                          input int src_gap, input int rdy_gap, input int dr_init,
                          input int abort_pops);
    int acc = 0, pop = 0, k = 0, nb, m_state = 0, m_left = 0, m_cnt, src_timer = 0, beats;
    bit fin = 1'b0, prev_dr;
    logic [AW-1:0] cur_addr = '0, exp_addr;
    nb = (total + bl) / (bl + 1);
    @(negedge clk);
    base_addr = base; total_words = LW'(total); burst_len = BLW'(bl); start = 1'b1;
    in_valid = 1'b0; ready = 1'b0; m_cnt = dr_init; dma_ready = (dr_init == 0);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done) begin
        fin = 1'b1;
        check("done_bursts", k, nb);
        check("done_pushed", acc, total);
        check("done_popped", pop, total);
        check("done_busy", busy, 0);
        check("done_valid", valid, 0);
        break;
      end
      // a start while busy must be ignored
      if (cyc == 3) begin
        start = 1'b1; base_addr = ~base; total_words = LW'(total + 5); burst_len = BLW'(bl ^ 1);
      end else begin
        start = 1'b0;
      end
      check("busy", busy, 1);
      check("in_ready", in_ready, ((acc - pop) != DEPTH) && (acc < total));

      prev_dr = dma_ready;
      ready = 1'b0;
      if (m_state == 0) begin
        if (m_cnt > 0) m_cnt--;
        dma_ready = (m_cnt == 0);
        if (valid) begin
          exp_addr = base + AW'(k * (bl + 1) * SW);
          beats = (bl + 1 < total - k * (bl + 1)) ? bl + 1 : total - k * (bl + 1);
          check("launch_dma_ready", prev_dr, 1);
          check("burst_index", k < nb, 1);
          check("burst_addr", addr, exp_addr);
          check("dma_len", dma_len, beats - 1);
          check("fill_at_launch", (acc - pop) >= beats, 1);
          cur_addr = addr; m_left = beats; k++; m_state = 1; dma_ready = 1'b0;
        end
      end else if (m_state == 2) begin
        check("valid_low_resp", valid, 0);
        ready = ($urandom_range(0, 2) == 0);
        if (m_cnt == 0) begin
          dma_ready = 1'b1; m_state = 0;
        end else begin
          m_cnt--;
        end
      end
      if (m_state == 1) begin
        check("valid_held", valid, 1);
        check("addr_stable", addr, cur_addr);
        ready = ($urandom_range(0, rdy_gap) == 0);
        if (ready) begin
          check("pop_nonempty", acc > pop, 1);
          if (acc > pop) begin
            check("wdata", wdata, words[pop]);
            check("wstrb", wstrb, strbs[pop]);
          end
          pop++; m_left--;
          if (m_left == 0) begin
            m_state = 2; m_cnt = $urandom_range(0, 4);
          end
        end
      end

      if (acc < total) begin
        if (src_timer > 0) begin
          src_timer--; in_valid = 1'b0;
        end else begin
          in_valid = 1'b1; in_data = words[acc]; in_strb = strbs[acc];
          if (in_ready) begin
            acc++; src_timer = src_gap;
          end
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1)); in_data = DW'($urandom); in_strb = '1;
      end

      if (abort_pops > 0 && pop == abort_pops) begin
        @(posedge clk);
        #1;
        ready = 1'b0; in_valid = 1'b0; dma_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("xfer_done_seen", fin, 1);
    ready = 1'b0; in_valid = 1'b0; dma_ready = 1'b1;
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr, 0);
    check("rst_dma_len", dma_len, 0);
    rst = 1'b0;

    // zero-length transfer: done two cycles after start, no burst
    @(negedge clk);
    total_words = '0; base_addr = 32'h1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_done_early", done, 0);
    check("zero_valid_a", valid, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_valid_b", valid, 0);
    @(negedge clk);
    check("zero_done_clear", done, 0);
    check("zero_busy", busy, 0);

    fill_words(4, 1'b1);
    run_xfer(32'h1000, 4, 3, 0, 0, 0, 0);
    fill_words(10, 1'b0);
    run_xfer(32'h1000, 10, 3, 0, 1, 0, 0);
    fill_words(20, 1'b0);
    run_xfer(32'h2000, 20, 15, 0, 0, 20, 0);
    fill_words(9, 1'b0);
    run_xfer(32'h3000, 9, 3, 4, 0, 0, 0);
    fill_words(8, 1'b0);
    run_xfer(32'hFFFF_FFF0, 8, 3, 0, 1, 0, 0);

    // reset after the second beat of the first burst
    fill_words(8, 1'b0);
    run_xfer(32'h4000, 8, 3, 0, 0, 0, 2);
    rst = 1'b1;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    fill_words(8, 1'b0);
    run_xfer(32'h5000, 8, 3, 1, 1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      int n, b;
      n = $urandom_range(1, 40);
      b = $urandom_range(0, 15);
      fill_words(n, 1'b0);
      run_xfer({$urandom_range(0, 32'h3FFF_FFFF), 2'b00} & 32'h0FFF_FFFC, n, b,
               $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 6), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
